// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder (LSB first, one bit per clock) with a
//            single full-adder cell, carry flop and valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int c_cnt_w = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    c_idle = 2'd0,
    c_add  = 2'd1,
    c_done = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_sum_sr;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_count;

  logic w_s;
  logic w_c;
  logic w_last;

  // The single bit cell shared by every bit position.
  assign w_s    = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_c    = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));
  assign w_last = (r_count == c_cnt_w'(WIDTH - 1));

  assign o_ready = (r_state == c_idle);
  assign o_valid = (r_state == c_done);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= c_idle;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
      o_sum    <= '0;
      o_carry  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (i_valid) begin
            r_a_sr  <= i_a;
            r_b_sr  <= i_b;
            r_carry <= i_cin;
            r_count <= '0;
            r_state <= c_add;
          end
        end
        c_add: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
          r_carry  <= w_c;
          r_count  <= r_count + c_cnt_w'(1);
          // Final bit: publish the completed sum, including this cycle's bit.
          if (w_last) begin
            o_sum   <= {w_s, r_sum_sr[WIDTH-1:1]};
            o_carry <= w_c;
            r_state <= c_done;
          end
        end
        c_done: begin
          if (i_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule
`default_nettype wire
